// File: rtl/irq_controller.sv
// irq_controller
//   Four-source interrupt controller. Raw lines are synchronised, rising
//   edges are latched into a pending register, a software mask gates
//   arbitration (source 0 highest priority), and a single request is run
//   through a request / acknowledge / end-of-interrupt handshake with the CPU.
//
// Parameters
//   ACK_TIMEOUT  cycles irq may stay high without irq_ack (1..255)
//
// Ports
//   clk         system clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   irq_in      raw interrupt lines (asynchronous), bit i = source i
//   mask_we     mask register write strobe
//   mask_wdata  new mask value, 1 = source disabled
//   irq_ack     CPU acknowledge pulse
//   eoi         CPU end-of-interrupt pulse
//   irq         registered interrupt request
//   irq_id      id of requested / in-service source
//   pending     pending register
//   mask        mask register
//   in_service  acknowledged interrupt awaiting EOI
module irq_controller #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] irq_in,
    input  logic       mask_we,
    input  logic [3:0] mask_wdata,
    input  logic       irq_ack,
    input  logic       eoi,
    output logic       irq,
    output logic [1:0] irq_id,
    output logic [3:0] pending,
    output logic [3:0] mask,
    output logic       in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [3:0] sync1, sync2, sync3;
    logic [3:0] edges;
    logic [3:0] eligible;
    logic [1:0] winner;
    logic       any_eligible;
    logic [3:0] clr;
    logic       irq_nxt;
    logic [1:0] irq_id_nxt;
    logic       in_service_nxt;
    logic [3:0] pending_nxt;
    logic [3:0] mask_nxt;

    // Two-flop synchroniser followed by a third flop used only for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edges    = sync2 & ~sync3;
    assign eligible = pending & ~mask;

    // Lowest set index wins.
    always_comb begin
        winner       = 2'd0;
        any_eligible = |eligible;
        if (eligible[0])      winner = 2'd0;
        else if (eligible[1]) winner = 2'd1;
        else if (eligible[2]) winner = 2'd2;
        else if (eligible[3]) winner = 2'd3;
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        irq_nxt        = irq;
        irq_id_nxt     = irq_id;
        in_service_nxt = in_service;
        mask_nxt       = mask_we ? mask_wdata : mask;
        clr            = '0;

        case (state)
            IDLE: begin
                irq_nxt = 1'b0;
                if (any_eligible) begin
                    irq_id_nxt = winner;
                    irq_nxt    = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = REQ;
                end
            end
            REQ: begin
                // Ack beats both a masking write and timeout expiry.
                if (irq_ack) begin
                    clr[irq_id]    = 1'b1;
                    irq_nxt        = 1'b0;
                    in_service_nxt = 1'b1;
                    state_nxt      = SERVICE;
                end else if (mask_we && mask_wdata[irq_id]) begin
                    irq_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else if (cnt == 8'(ACK_TIMEOUT - 1)) begin
                    // irq was raised on the IDLE->REQ edge with cnt = 0, so
                    // dropping at cnt = ACK_TIMEOUT-1 keeps it high exactly
                    // ACK_TIMEOUT cycles.
                    irq_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            SERVICE: begin
                irq_nxt = 1'b0;
                if (eoi) begin
                    in_service_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: begin
                irq_nxt        = 1'b0;
                in_service_nxt = 1'b0;
                state_nxt      = IDLE;
            end
        endcase

        // A new edge wins over a clear in the same cycle.
        pending_nxt = (pending & ~clr) | edges;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            irq        <= 1'b0;
            irq_id     <= '0;
            in_service <= 1'b0;
            pending    <= '0;
            mask       <= '1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            irq        <= irq_nxt;
            irq_id     <= irq_id_nxt;
            in_service <= in_service_nxt;
            pending    <= pending_nxt;
            mask       <= mask_nxt;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller
//   Self-checking bench for irq_controller (ACK_TIMEOUT = 4). Expected grant
//   ids are queued as stimulus is driven and popped when irq rises.
module tb_irq_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       irq_ack;
    logic       eoi;
    logic       irq;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] mask;
    logic       in_service;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_id;

    irq_controller #(.ACK_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .irq_ack    (irq_ack),
        .eoi        (eoi),
        .irq        (irq),
        .irq_id     (irq_id),
        .pending    (pending),
        .mask       (mask),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_mask(input logic [3:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        step(1);
        mask_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
    endtask

    task automatic wait_irq(input int max, output bit got);
        int i;
        got = 1'b0;
        i = 0;
        while (i <= max && !got) begin
            if (irq === 1'b1) got = 1'b1;
            else begin
                step(1);
                i++;
            end
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({irq, irq_id, pending, mask, in_service} !== {1'b0, 2'd0, 4'b0000, 4'b1111, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got irq=%b id=%0d pend=%b mask=%b insvc=%b, want 0 0 0000 1111 0",
                     irq, irq_id, pending, mask, in_service);
        end
    endtask

    task automatic test_basic();
        write_mask(4'b0000);
        n_tests++;
        if (mask !== 4'b0000) begin n_fail++; $display("FAIL basic_mask: got %b want 0000", mask); end
        irq_in[2] = 1'b1;
        exp_q.push_back(2'd2);
        step(2);
        n_tests++;
        if (pending !== 4'b0000) begin n_fail++; $display("FAIL basic_pend_early: got %b want 0000", pending); end
        step(1);
        n_tests++;
        if (pending !== 4'b0100 || irq !== 1'b0) begin
            n_fail++; $display("FAIL basic_pend: got pend=%b irq=%b want 0100 0", pending, irq);
        end
        step(1);
        exp_id = exp_q.pop_front();
        n_tests++;
        if (irq !== 1'b1 || irq_id !== exp_id) begin
            n_fail++; $display("FAIL basic_latency: got irq=%b id=%0d want 1 %0d", irq, irq_id, exp_id);
        end
        irq_in = 4'b0000;
        pulse_ack();
        n_tests++;
        if (irq !== 1'b0 || in_service !== 1'b1 || pending !== 4'b0000) begin
            n_fail++; $display("FAIL basic_ack: got irq=%b insvc=%b pend=%b want 0 1 0000", irq, in_service, pending);
        end
        pulse_eoi();
        n_tests++;
        if (in_service !== 1'b0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL basic_eoi: got insvc=%b irq=%b want 0 0", in_service, irq);
        end
    endtask

    task automatic test_priority();
        bit got;
        irq_in = 4'b1010;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        wait_irq(10, got);
        exp_id = exp_q.pop_front();
        n_tests++;
        if (!got || irq_id !== exp_id) begin
            n_fail++; $display("FAIL prio_first: got irq=%b id=%0d want 1 %0d", irq, irq_id, exp_id);
        end
        pulse_ack();
        pulse_eoi();
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL prio_eoi_gap: got irq=%b want 0", irq); end
        step(1);
        exp_id = exp_q.pop_front();
        n_tests++;
        if (irq !== 1'b1 || irq_id !== exp_id || pending !== 4'b1000) begin
            n_fail++; $display("FAIL prio_second: got irq=%b id=%0d pend=%b want 1 %0d 1000", irq, irq_id, pending, exp_id);
        end
        pulse_ack();
        pulse_eoi();
        irq_in = 4'b0000;
    endtask

    task automatic test_masked();
        bit got;
        write_mask(4'b1111);
        irq_in = 4'b1111;
        step(1);
        irq_in = 4'b0000;
        step(5);
        n_tests++;
        if (pending !== 4'b1111 || irq !== 1'b0) begin
            n_fail++; $display("FAIL masked_pend: got pend=%b irq=%b want 1111 0", pending, irq);
        end
        exp_q.push_back(2'd3);
        write_mask(4'b0111);
        wait_irq(5, got);
        exp_id = exp_q.pop_front();
        n_tests++;
        if (!got || irq_id !== exp_id) begin
            n_fail++; $display("FAIL masked_unmask3: got irq=%b id=%0d want 1 %0d", irq, irq_id, exp_id);
        end
        pulse_ack();
        pulse_eoi();
        // Drain the remaining pending sources in priority order.
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        write_mask(4'b0000);
        for (int i = 0; i < 3; i++) begin
            wait_irq(5, got);
            exp_id = exp_q.pop_front();
            n_tests++;
            if (!got || irq_id !== exp_id) begin
                n_fail++; $display("FAIL masked_drain%0d: got irq=%b id=%0d want 1 %0d", i, irq, irq_id, exp_id);
            end
            pulse_ack();
            pulse_eoi();
        end
        n_tests++;
        if (pending !== 4'b0000) begin n_fail++; $display("FAIL masked_drained: got %b want 0000", pending); end
    endtask

    task automatic test_timeout();
        bit got;
        int hi;
        bit pend_ok;
        irq_in[1] = 1'b1;
        step(1);
        irq_in = 4'b0000;
        exp_q.push_back(2'd1);
        wait_irq(10, got);
        exp_id = exp_q.pop_front();
        n_tests++;
        if (!got || irq_id !== exp_id) begin
            n_fail++; $display("FAIL timeout_first: got irq=%b id=%0d want 1 %0d", irq, irq_id, exp_id);
        end
        hi = 0;
        pend_ok = 1'b1;
        while (irq === 1'b1 && hi < 20) begin
            hi++;
            if (pending !== 4'b0010) pend_ok = 1'b0;
            step(1);
        end
        n_tests++;
        if (hi != 4) begin n_fail++; $display("FAIL timeout_high_len: got %0d cycles want 4", hi); end
        n_tests++;
        if (pending !== 4'b0010 || !pend_ok) begin
            n_fail++; $display("FAIL timeout_pend: got %b want 0010 throughout", pending);
        end
        exp_q.push_back(2'd1);
        step(1);
        exp_id = exp_q.pop_front();
        n_tests++;
        if (irq !== 1'b1 || irq_id !== exp_id) begin
            n_fail++; $display("FAIL timeout_rearm: got irq=%b id=%0d want 1 %0d", irq, irq_id, exp_id);
        end
        // Ack on the same edge the timeout would expire.
        step(3);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        n_tests++;
        if (in_service !== 1'b1 || irq !== 1'b0 || pending !== 4'b0000) begin
            n_fail++; $display("FAIL timeout_ack_wins: got insvc=%b irq=%b pend=%b want 1 0 0000", in_service, irq, pending);
        end
        pulse_eoi();
    endtask

    task automatic test_service_edges();
        bit got;
        irq_in[0] = 1'b1;
        step(1);
        irq_in = 4'b0000;
        exp_q.push_back(2'd0);
        wait_irq(10, got);
        exp_id = exp_q.pop_front();
        n_tests++;
        if (!got || irq_id !== exp_id) begin
            n_fail++; $display("FAIL svc_first: got irq=%b id=%0d want 1 %0d", irq, irq_id, exp_id);
        end
        pulse_ack();
        irq_in[0] = 1'b1;
        step(1);
        irq_in = 4'b0000;
        exp_q.push_back(2'd0);
        step(4);
        n_tests++;
        if (pending !== 4'b0001 || irq !== 1'b0 || in_service !== 1'b1) begin
            n_fail++; $display("FAIL svc_accum: got pend=%b irq=%b insvc=%b want 0001 0 1", pending, irq, in_service);
        end
        pulse_eoi();
        n_tests++;
        if (irq !== 1'b0 || in_service !== 1'b0) begin
            n_fail++; $display("FAIL svc_eoi: got irq=%b insvc=%b want 0 0", irq, in_service);
        end
        step(1);
        exp_id = exp_q.pop_front();
        n_tests++;
        if (irq !== 1'b1 || irq_id !== exp_id) begin
            n_fail++; $display("FAIL svc_rereq: got irq=%b id=%0d want 1 %0d", irq, irq_id, exp_id);
        end
        // Rising edge detected in the same cycle as the ack clears pending[0].
        irq_in[0] = 1'b1;
        step(2);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        n_tests++;
        if (in_service !== 1'b1 || pending[0] !== 1'b1) begin
            n_fail++; $display("FAIL svc_set_wins: got insvc=%b pend=%b want 1 xxx1", in_service, pending);
        end
        irq_in = 4'b0000;
        exp_q.push_back(2'd0);
        pulse_eoi();
        step(1);
        exp_id = exp_q.pop_front();
        n_tests++;
        if (irq !== 1'b1 || irq_id !== exp_id) begin
            n_fail++; $display("FAIL svc_set_wins_req: got irq=%b id=%0d want 1 %0d", irq, irq_id, exp_id);
        end
        pulse_ack();
        pulse_eoi();
    endtask

    task automatic test_reset_midflight();
        bit got;
        bit quiet;
        irq_in[3] = 1'b1;
        step(1);
        irq_in = 4'b0000;
        exp_q.push_back(2'd3);
        wait_irq(10, got);
        exp_id = exp_q.pop_front();
        n_tests++;
        if (!got || irq_id !== exp_id) begin
            n_fail++; $display("FAIL rst_req_setup: got irq=%b id=%0d want 1 %0d", irq, irq_id, exp_id);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({irq, irq_id, pending, mask, in_service} !== {1'b0, 2'd0, 4'b0000, 4'b1111, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_in_req: got irq=%b id=%0d pend=%b mask=%b insvc=%b want 0 0 0000 1111 0",
                     irq, irq_id, pending, mask, in_service);
        end
        step(1);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (irq !== 1'b0) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet) begin n_fail++; $display("FAIL rst_req_quiet: got irq=1 after release want 0"); end

        write_mask(4'b0000);
        irq_in[2] = 1'b1;
        step(1);
        irq_in = 4'b0000;
        exp_q.push_back(2'd2);
        wait_irq(10, got);
        exp_id = exp_q.pop_front();
        pulse_ack();
        n_tests++;
        if (!got || irq_id !== exp_id || in_service !== 1'b1) begin
            n_fail++; $display("FAIL rst_svc_setup: got id=%0d insvc=%b want %0d 1", irq_id, in_service, exp_id);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({irq, irq_id, pending, mask, in_service} !== {1'b0, 2'd0, 4'b0000, 4'b1111, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_in_svc: got irq=%b id=%0d pend=%b mask=%b insvc=%b want 0 0 0000 1111 0",
                     irq, irq_id, pending, mask, in_service);
        end
        step(1);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (irq !== 1'b0 || in_service !== 1'b0) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet) begin n_fail++; $display("FAIL rst_svc_quiet: irq/in_service active after release, want 0"); end
    endtask

    initial begin
        rst_n      = 1'b0;
        irq_in     = 4'b0000;
        mask_we    = 1'b0;
        mask_wdata = 4'b0000;
        irq_ack    = 1'b0;
        eoi        = 1'b0;
        step(3);
        test_reset();
        rst_n = 1'b1;
        step(2);
        test_reset();
        test_basic();
        test_priority();
        test_masked();
        test_timeout();
        test_service_edges();
        test_reset_midflight();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
